// File: rtl/sumsq_frame_feeder.sv
// sumsq_frame_feeder: squares signed samples, sums them over a 2**FRAME_LOG2 frame and emits a saturated radicand with a start pulse.
// Define ENERGY_MEAN_EN to emit the frame mean square (sum >> FRAME_LOG2) instead of the raw sum.
module sumsq_frame_feeder #(
   parameter int SAMPLE_BITS   = 8,
   parameter int FRAME_LOG2    = 4,
   parameter int RADICAND_BITS = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic signed [SAMPLE_BITS-1:0] in_sample,
   input  logic                          frame_abort,
   output logic                          start,
   output logic [RADICAND_BITS-1:0]      radicand,
   output logic                          sat,
   output logic [FRAME_LOG2-1:0]         sample_cnt
);
   localparam int SQ_W  = 2 * SAMPLE_BITS;
   localparam int ACC_W = SQ_W + FRAME_LOG2;
   localparam int XW    = ACC_W > RADICAND_BITS ? ACC_W : RADICAND_BITS;
   logic signed [SQ_W-1:0]   sq_s;
   logic [SQ_W-1:0]          sq_reg;
   logic                     sq_vld;
   logic                     sq_last;
   logic [ACC_W-1:0]         acc;
   logic [ACC_W-1:0]         sum;
   logic [ACC_W-1:0]         val;
   logic [XW-1:0]            ext;
   logic                     ovf;
   logic [RADICAND_BITS-1:0] rad_n;
   // most negative sample squared still fits 2*SAMPLE_BITS unsigned
   assign sq_s = SQ_W'(in_sample) * SQ_W'(in_sample);
   assign sum  = acc + ACC_W'(sq_reg);
`ifdef ENERGY_MEAN_EN
   assign val  = sum >> FRAME_LOG2;
`else
   assign val  = sum;
`endif
   assign ext   = XW'(val);
   assign ovf   = |(ext >> RADICAND_BITS);
   assign rad_n = ovf ? '1 : ext[RADICAND_BITS-1:0];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sq_reg     <= '0;
         sq_vld     <= 1'b0;
         sq_last    <= 1'b0;
         acc        <= '0;
         start      <= 1'b0;
         radicand   <= '0;
         sat        <= 1'b0;
         sample_cnt <= '0;
      end else begin
         sq_vld <= in_valid & ~frame_abort;
         start  <= sq_vld & sq_last & ~frame_abort;
         if (frame_abort) begin
            sample_cnt <= '0;
            acc        <= '0;
         end else begin
            if (in_valid) begin
               sq_reg     <= sq_s;
               sq_last    <= &sample_cnt;
               sample_cnt <= sample_cnt + 1'b1;
            end
            if (sq_vld) begin
               acc <= sq_last ? '0 : sum;
               if (sq_last) begin
                  radicand <= rad_n;
                  sat      <= ovf;
               end
            end
         end
      end
endmodule
